// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative RV32M divider.
//   div_op_e    - 2-bit operation encoding as presented on i_op.
//   div_state_e - controller states.
//   DIV_ALL_ONES, DIV_INT_MIN - special-case result values.
//   neg2c()     - XLEN-bit two's-complement negation, computed unsigned.
package div_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } div_state_e;

  localparam logic [XLEN-1:0] DIV_ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] DIV_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // Negating INT_MIN yields INT_MIN, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
//   part_rem - partial remainder entering the step
//   dvd_bit  - next dividend bit shifted into the remainder
//   divisor  - divisor magnitude
//   next_rem - partial remainder leaving the step
//   q_bit    - quotient bit produced by the step
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] part_rem,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_rem,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            unused_diff_bit;

  // Difference is evaluated one bit wider than the shifted remainder so the
  // top bit is a clean borrow flag.
  assign shifted = {part_rem, dvd_bit};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~diff[XLEN+1];

  // The restoring invariant (part_rem < divisor) keeps every kept value
  // inside XLEN bits, so bit XLEN of either candidate is always zero.
  assign next_rem        = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign unused_diff_bit = diff[XLEN];

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV, DIVU, REM, REMU).
//   i_clk, i_reset         - clock, asynchronous active-high reset
//   i_start, i_op          - request and operation, accepted while idle
//   i_rs1_data, i_rs2_data - dividend and divisor from the register file
//   i_rd_addr              - destination register
//   i_flush                - abort the operation in flight, no result
//   o_busy                 - high in every state except IDLE
//   o_rd_addr, o_rd_data   - registered result and its destination
//   o_rd_wren              - one-cycle write strobe, never for x0
//   o_valid                - one-cycle completion pulse
module div_unit
  import div_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_flush,
  output logic            o_busy,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren,
  output logic            o_valid
);

  div_state_e      state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic            is_rem_q, is_rem_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] rd_data_d;
  logic [4:0]      rd_addr_d;
  logic            valid_d, wren_d;

  // Request decode
  div_op_e         op_in;
  logic            in_signed, in_rem, sign1, sign2;
  logic            div_zero, overflow;
  logic [XLEN-1:0] special_res;

  // Step and sign fix-up
  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] quot_fix, rem_fix;

  div_step u_step (
    .part_rem (rem_q),
    .dvd_bit  (dvd_q[XLEN-1]),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  assign o_busy = (state_q != IDLE);

  // NOTE: every signal written here is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    op_in      = div_op_e'(i_op);
    in_signed  = (op_in == DIV) || (op_in == REM);
    in_rem     = (op_in == REM) || (op_in == REMU);
    sign1      = in_signed & i_rs1_data[XLEN-1];
    sign2      = in_signed & i_rs2_data[XLEN-1];
    div_zero   = (i_rs2_data == '0);
    overflow   = in_signed && (i_rs1_data == DIV_INT_MIN) && (i_rs2_data == DIV_ALL_ONES);
    if (div_zero) special_res = in_rem ? i_rs1_data : DIV_ALL_ONES;
    else          special_res = in_rem ? '0 : DIV_INT_MIN;

    quot_fix   = neg_quot_q ? neg2c(dvd_q) : dvd_q;
    rem_fix    = neg_rem_q  ? neg2c(rem_q) : rem_q;

    state_d    = state_q;
    count_d    = count_q;
    is_rem_d   = is_rem_q;
    rd_d       = rd_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rd_data_d  = o_rd_data;
    rd_addr_d  = o_rd_addr;
    valid_d    = 1'b0;
    wren_d     = 1'b0;

    if (i_flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            is_rem_d   = in_rem;
            rd_d       = i_rd_addr;
            dvd_d      = sign1 ? neg2c(i_rs1_data) : i_rs1_data;
            dvs_d      = sign2 ? neg2c(i_rs2_data) : i_rs2_data;
            rem_d      = '0;
            neg_quot_d = sign1 ^ sign2;
            neg_rem_d  = sign1;
            count_d    = '0;
            if (div_zero || overflow) begin
              state_d   = DONE;
              rd_data_d = special_res;
              rd_addr_d = i_rd_addr;
              valid_d   = 1'b1;
              wren_d    = (i_rd_addr != '0);
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = step_rem;
          dvd_d = {dvd_q[XLEN-2:0], step_q};
          if (count_q == 5'(XLEN-1)) state_d = FIXUP;
          else                       count_d = count_q + 5'd1;
        end
        FIXUP: begin
          rd_data_d = is_rem_q ? rem_fix : quot_fix;
          rd_addr_d = rd_q;
          valid_d   = 1'b1;
          wren_d    = (rd_q != '0);
          state_d   = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q    <= '0;
      is_rem_q   <= 1'b0;
      rd_q       <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      o_rd_data  <= '0;
      o_rd_addr  <= '0;
      o_valid    <= 1'b0;
      o_rd_wren  <= 1'b0;
    end else begin
      count_q    <= count_d;
      is_rem_q   <= is_rem_d;
      rd_q       <= rd_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      o_rd_data  <= rd_data_d;
      o_rd_addr  <= rd_addr_d;
      o_valid    <= valid_d;
      o_rd_wren  <= wren_d;
    end
  end

endmodule
